// File: rtl/lif_timestep_scheduler_if.sv
// ---------------------------------------------------------------------------
// lif_timestep_scheduler_if
//   Handshake bundle for the LIF timestep scheduler.
//   Input channel : in_valid / in_idx / in_cur  -> in_ready
//   Spike channel : sp_valid / sp_idx           -> sp_ready
//   master : the environment side (drives input events, accepts spikes)
//   slave  : the scheduler side
// ---------------------------------------------------------------------------
interface lif_timestep_scheduler_if #(
    parameter int IDX_W = 4,
    parameter int I_W   = 8
);
    logic             in_valid;
    logic [IDX_W-1:0] in_idx;
    logic [I_W-1:0]   in_cur;
    logic             in_ready;

    logic             sp_valid;
    logic [IDX_W-1:0] sp_idx;
    logic             sp_ready;

    modport master (
        output in_valid, in_idx, in_cur, sp_ready,
        input  in_ready, sp_valid, sp_idx
    );

    modport slave (
        input  in_valid, in_idx, in_cur, sp_ready,
        output in_ready, sp_valid, sp_idx
    );
endinterface

// File: rtl/lif_timestep_scheduler.sv
// ---------------------------------------------------------------------------
// lif_timestep_scheduler
//   Shares one leaky-integrate-and-fire update datapath across N_NEURONS
//   neurons. Input currents accumulate into a double-buffered per-neuron
//   accumulator; each accepted tick sweeps all neurons one per cycle
//   (leak, integrate, threshold, reset, refractory) and emits spikes on a
//   valid/ready channel.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   tick         timestep start request (accepted only when idle)
//   bus          slave side of lif_timestep_scheduler_if
//                (input current events in, spike events out)
//   busy         high whenever a sweep is in progress (state != IDLE)
//   done         one-cycle pulse at the end of a sweep
//   tick_missed  sticky flag: a tick arrived while busy; cleared by reset
// ---------------------------------------------------------------------------
module lif_timestep_scheduler #(
    parameter int N_NEURONS  = 16,
    parameter int IDX_W      = 4,
    parameter int V_W        = 8,
    parameter int I_W        = 8,
    parameter int ACC_W      = 10,
    parameter int LEAK_SHIFT = 3,
    parameter int V_TH       = 20,
    parameter int V_RESET    = 0,
    parameter int T_REF      = 2,
    parameter int REF_W      = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           tick,
    lif_timestep_scheduler_if.slave        bus,
    output logic                           busy,
    output logic                           done,
    output logic                           tick_missed
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UPDATE = 2'd1;
    localparam logic [1:0] S_SPIKE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Wide enough that v - leak + acc can never wrap before saturation.
    localparam int SUM_W = V_W + ACC_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_NEURONS - 1);
    localparam logic [V_W-1:0]   V_TH_L    = V_W'(V_TH);
    localparam logic [V_W-1:0]   V_RESET_L = V_W'(V_RESET);
    localparam logic [REF_W-1:0] T_REF_L   = REF_W'(T_REF);

    logic [1:0]                            state_q, state_d;
    logic [IDX_W-1:0]                      idx_q, idx_d;
    logic                                  wbank_q, wbank_d;
    logic                                  tick_missed_q, tick_missed_d;
    logic [N_NEURONS-1:0][V_W-1:0]         v_q, v_d;
    logic [N_NEURONS-1:0][REF_W-1:0]       ref_q, ref_d;
    logic [1:0][N_NEURONS-1:0][ACC_W-1:0]  acc_q, acc_d;

    logic              rbank;
    logic [V_W-1:0]    v_cur;
    logic [ACC_W-1:0]  acc_cur;
    logic [REF_W-1:0]  ref_cur;
    logic [SUM_W-1:0]  v_ext;
    logic [V_W-1:0]    v_sat;
    logic [ACC_W:0]    acc_sum;
    logic              in_fire;
    logic              is_last;
    logic              fires;

    // The sweep reads the bank that was being written before the tick;
    // new inputs keep landing in wbank, so the two never collide.
    assign rbank   = ~wbank_q;
    assign v_cur   = v_q[idx_q];
    assign acc_cur = acc_q[rbank][idx_q];
    assign ref_cur = ref_q[idx_q];

    assign v_ext   = SUM_W'(v_cur) - SUM_W'(v_cur >> LEAK_SHIFT) + SUM_W'(acc_cur);
    assign v_sat   = (|v_ext[SUM_W-1:V_W]) ? '1 : v_ext[V_W-1:0];
    assign fires   = (ref_cur == '0) && (v_sat >= V_TH_L);

    assign in_fire = bus.in_valid & bus.in_ready;
    assign acc_sum = {1'b0, acc_q[wbank_q][bus.in_idx]} + (ACC_W+1)'(bus.in_cur);
    assign is_last = (idx_q == LAST_IDX);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wbank_d       = wbank_q;
        tick_missed_d = tick_missed_q | (tick & (state_q != S_IDLE));
        v_d           = v_q;
        ref_d         = ref_q;
        acc_d         = acc_q;

        // Uses the pre-toggle wbank, so an event in the tick cycle joins this sweep.
        if (in_fire) begin
            acc_d[wbank_q][bus.in_idx] = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        end

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    wbank_d = ~wbank_q;
                    idx_d   = '0;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                acc_d[rbank][idx_q] = '0;
                if (ref_cur != '0) begin
                    ref_d[idx_q] = ref_cur - REF_W'(1);
                    v_d[idx_q]   = V_RESET_L;
                end else if (fires) begin
                    ref_d[idx_q] = T_REF_L;
                    v_d[idx_q]   = V_RESET_L;
                end else begin
                    v_d[idx_q]   = v_sat;
                end

                // A spiking neuron parks idx here; SPIKE advances it.
                if (fires)        state_d = S_SPIKE;
                else if (is_last) state_d = S_DONE;
                else              idx_d   = idx_q + IDX_W'(1);
            end
            S_SPIKE: begin
                if (bus.sp_ready) begin
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_UPDATE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            wbank_q       <= 1'b0;
            tick_missed_q <= 1'b0;
            v_q           <= {N_NEURONS{V_RESET_L}};
            ref_q         <= '0;
            acc_q         <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wbank_q       <= wbank_d;
            tick_missed_q <= tick_missed_d;
            v_q           <= v_d;
            ref_q         <= ref_d;
            acc_q         <= acc_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign tick_missed  = tick_missed_q;
    assign bus.sp_valid = (state_q == S_SPIKE);
    assign bus.sp_idx   = idx_q;     // idx is frozen while in SPIKE
    assign bus.in_ready = ~reset;

endmodule
